axi_s_mem: RTL and testbench
============================

# axi_s_mem

AXI3-subset slave (responder) with an internal word-addressed RAM. It serves read and write bursts from the core-side AXI master, 32-bit data, up to 16 beats. It is used as the simulation/FPGA backing memory behind the core's AXI master port. Read and write channels are independent and may run concurrently.

## Interface
- SLV_ADDR_BASE, 32'h00000000, byte address of word 0
- DEPTH_WORDS, 1024, RAM depth in WIDTH_DA words; power of two
- WIDTH_ID, 1, ID width
- WIDTH_AD, 32, address width
- WIDTH_DA, 32, data width; only 32 supported
- S_AXI_ACLK  in  1  clock; all logic on rising edge
- S_AXI_ARESET  in  1  synchronous, active-high reset
- S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  WIDTH_ID/WIDTH_AD/4/3/2  write address; AWSIZE ignored (full word assumed)
- S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  write address handshake
- S_AXI_WDATA  in  WIDTH_DA  write data
- S_AXI_WSTRB  in  WIDTH_DA/8  byte enables
- S_AXI_WLAST, S_AXI_WVALID in 1; S_AXI_WREADY out 1
- S_AXI_BID out WIDTH_ID, S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1
- S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  WIDTH_ID/WIDTH_AD/4/3/2  read address; ARSIZE ignored
- S_AXI_ARVALID in 1, S_AXI_ARREADY out 1
- S_AXI_RID out WIDTH_ID, S_AXI_RDATA out WIDTH_DA, S_AXI_RRESP out 2, S_AXI_RLAST out 1, S_AXI_RVALID out 1, S_AXI_RREADY in 1

## Operation
- Address decode: word index = (addr - SLV_ADDR_BASE) >> 2. In range iff 0 <= index < DEPTH_WORDS, evaluated per beat; addr[1:0] ignored.
- Burst: 2'b00 FIXED keeps the address constant. 2'b01 INCR adds 4 per beat, no wrap at DEPTH_WORDS; beats past the end are out of range. 2'b10/2'b11 are executed as INCR and the burst response is SLVERR.
- Beat count = AxLEN+1; AxLEN is latched at address handshake and governs the burst, not WLAST.
- Write FSM, states W_Idle -> W_Data -> W_Resp -> W_Idle:
  - W_Idle: AWREADY=1. On AWVALID&AWREADY: latch AWID, AWADDR, AWLEN, AWBURST; beat counter=0; go to W_Data.
  - W_Data: WREADY=1. Each WVALID&WREADY writes the bytes with WSTRB=1 at the current word (dropped if out of range) and advances address/counter. On beat AWLEN go to W_Resp.
  - W_Resp: BVALID=1, BID=latched AWID, BRESP is sticky over the burst: OKAY=2'b00, or SLVERR=2'b10 if any beat was out of range, burst type unsupported, or WLAST != (beat==AWLEN) on any beat. On BVALID&BREADY go to W_Idle.
- Read FSM, states R_Idle -> R_Data -> R_Idle:
  - R_Idle: ARREADY=1. On handshake latch ARID, ARADDR, ARLEN, ARBURST; load RDATA from the first word; go to R_Data.
  - R_Data: RVALID=1, RID=ARID, RLAST=(beat==ARLEN). RRESP per beat: SLVERR if that beat is out of range (RDATA=0) or burst type unsupported.
  - On RVALID&RREADY: if not last, load the next word into RDATA; if last, go to R_Idle. RDATA/RLAST/RRESP hold while RREADY=0.
- Concurrent read/write to the same word in the same cycle: the read returns pre-write contents.
- Reset: both FSMs go to idle and all outputs go to their reset values. RAM contents are retained, not cleared. Reset mid-burst abandons the burst with no response.

## Timing
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BRESP, RRESP, BID, RID, RDATA = 0.
- AWREADY/ARREADY rise the first cycle after reset deasserts.
- All outputs are registered; no combinational input-to-output paths.
- Write path:
  - AW handshake at cycle T: AWREADY=0 and WREADY=1 from T+1.
  - Last W beat at cycle U: WREADY=0 and BVALID=1 from U+1.
  - B handshake at V: AWREADY=1 from V+1.
  - WVALID presented before the AW handshake is not accepted (WREADY=0 in W_Idle).
- Read path:
  - AR handshake at T: RVALID=1 with beat 0 at T+1.
  - With RREADY held high, one beat per cycle: beat k at T+1+k.
  - Last beat accepted at U: ARREADY=1 from U+1.
- Minimum turnaround: a single-beat write takes 3 cycles from AW handshake to AWREADY reasserted (B accepted immediately); a single-beat read takes 2 cycles.

## Test plan
- Reset, then INCR write AWADDR=BASE+0x10, AWLEN=3, data 0x11111111..0x44444444, WSTRB=4'hF -> BRESP=OKAY, BID echoes AWID. Read of the same burst -> identical four words, RLAST only on beat 3.
- Write WSTRB=4'b0101, data 0xAABBCCDD over word 0x12345678 -> read returns 0x12BB56DD.
- FIXED write, AWLEN=2, data A,B,C -> address holds C. FIXED read, ARLEN=2 -> C,C,C.
- INCR read starting at the last valid word, ARLEN=1 -> beat 0 OKAY with data; beat 1 SLVERR with RDATA=0. Same pattern on write -> BRESP=SLVERR, in-range word written.
- RREADY toggled 1,0,0,1,... and BREADY held low 5 cycles -> RDATA/RLAST/BVALID stable while stalled. No AWREADY until the B handshake.
- Reset asserted mid read burst (after beat 1) -> RVALID=0 next cycle, ARREADY=1 after release, RAM retains earlier writes. WLAST early on beat 1 of a 4-beat write -> BRESP=SLVERR.

Source files
------------

// File: rtl/axi_s_mem.sv
// axi_s_mem
// AXI3-subset slave backed by an internal word-addressed RAM. It serves the
// core-side AXI master with 32-bit read and write bursts of up to 16 beats.
// The read and write channels are fully independent and may run at the same
// time.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESET : clock and synchronous active-high reset
//   S_AXI_AW*                 : write address channel (AWSIZE is ignored)
//   S_AXI_W*                  : write data channel with byte strobes
//   S_AXI_B*                  : write response channel
//   S_AXI_AR*                 : read address channel (ARSIZE is ignored)
//   S_AXI_R*                  : read data channel
//
// Every output comes from a flop, so there is no combinational path from an
// input to an output.
module axi_s_mem #(
    parameter logic [31:0] SLV_ADDR_BASE = 32'h0000_0000,
    parameter int          DEPTH_WORDS   = 1024,
    parameter int          WIDTH_ID      = 1,
    parameter int          WIDTH_AD      = 32,
    parameter int          WIDTH_DA      = 32
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    input  logic [WIDTH_ID-1:0]   S_AXI_AWID,
    input  logic [WIDTH_AD-1:0]   S_AXI_AWADDR,
    input  logic [3:0]            S_AXI_AWLEN,
    input  logic [2:0]            S_AXI_AWSIZE,
    input  logic [1:0]            S_AXI_AWBURST,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [WIDTH_DA-1:0]   S_AXI_WDATA,
    input  logic [WIDTH_DA/8-1:0] S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [WIDTH_ID-1:0]   S_AXI_BID,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [WIDTH_ID-1:0]   S_AXI_ARID,
    input  logic [WIDTH_AD-1:0]   S_AXI_ARADDR,
    input  logic [3:0]            S_AXI_ARLEN,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [WIDTH_ID-1:0]   S_AXI_RID,
    output logic [WIDTH_DA-1:0]   S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam int          STRB_W      = WIDTH_DA / 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_Idle, W_Data, W_Resp} wState_t;
    typedef enum logic       {R_Idle, R_Data}         rState_t;

    // Transfer size is always one full word, so the size fields carry no information.
    logic unusedSizeBits;
    assign unusedSizeBits = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

    logic [WIDTH_DA-1:0] mem [DEPTH_WORDS];

    // The subtraction wraps for addresses below the base, which pushes them out of range.
    function automatic logic [WIDTH_AD-1:0] wordOffset(input logic [WIDTH_AD-1:0] addr);
        return (addr - WIDTH_AD'(SLV_ADDR_BASE)) >> 2;
    endfunction

    function automatic logic addrInRange(input logic [WIDTH_AD-1:0] addr);
        return wordOffset(addr) < WIDTH_AD'(DEPTH_WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] addrIndex(input logic [WIDTH_AD-1:0] addr);
        logic [WIDTH_AD-1:0] off;
        off = wordOffset(addr);
        return off[IDX_W-1:0];
    endfunction

    // Only FIXED holds the address. INCR and both reserved burst types step one word.
    function automatic logic [WIDTH_AD-1:0] nextBeatAddr(input logic [WIDTH_AD-1:0] addr,
                                                         input logic [1:0] burst);
        return (burst == BURST_FIXED) ? addr : addr + WIDTH_AD'(4);
    endfunction

    // ---------------- write channel ----------------
    wState_t             wState_q, wState_d;
    logic [WIDTH_ID-1:0] awId_q, awId_d;
    logic [WIDTH_AD-1:0] awAddr_q, awAddr_d;
    logic [3:0]          awLen_q, awLen_d;
    logic [1:0]          awBurst_q, awBurst_d;
    logic [3:0]          wBeat_q, wBeat_d;
    logic                wErr_q, wErr_d;
    logic                awReady_q, wReady_q, bValid_q;
    logic                memWe;

    // Write FSM next state. AWLEN, not WLAST, ends the burst. Any WLAST that
    // disagrees with the beat count only marks the response as an error.
    always_comb begin
        wState_d  = wState_q;
        awId_d    = awId_q;
        awAddr_d  = awAddr_q;
        awLen_d   = awLen_q;
        awBurst_d = awBurst_q;
        wBeat_d   = wBeat_q;
        wErr_d    = wErr_q;
        memWe     = 1'b0;
        case (wState_q)
            W_Idle: begin
                if (S_AXI_AWVALID && awReady_q) begin
                    awId_d    = S_AXI_AWID;
                    awAddr_d  = S_AXI_AWADDR;
                    awLen_d   = S_AXI_AWLEN;
                    awBurst_d = S_AXI_AWBURST;
                    wBeat_d   = 4'd0;
                    wErr_d    = S_AXI_AWBURST[1];
                    wState_d  = W_Data;
                end
            end
            W_Data: begin
                if (S_AXI_WVALID && wReady_q) begin
                    memWe    = addrInRange(awAddr_q);
                    wErr_d   = wErr_q | ~addrInRange(awAddr_q)
                             | (S_AXI_WLAST != (wBeat_q == awLen_q));
                    awAddr_d = nextBeatAddr(awAddr_q, awBurst_q);
                    wBeat_d  = wBeat_q + 4'd1;
                    if (wBeat_q == awLen_q) begin
                        wState_d = W_Resp;
                    end
                end
            end
            W_Resp: begin
                if (S_AXI_BREADY && bValid_q) begin
                    wState_d = W_Idle;
                end
            end
            default: wState_d = W_Idle;
        endcase
    end

    // The handshake flags are registered from the next state. This keeps them
    // low during reset, and they rise on the first clock edge after reset releases.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wState_q  <= W_Idle;
            awId_q    <= '0;
            awAddr_q  <= '0;
            awLen_q   <= '0;
            awBurst_q <= '0;
            wBeat_q   <= '0;
            wErr_q    <= 1'b0;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            bValid_q  <= 1'b0;
        end else begin
            wState_q  <= wState_d;
            awId_q    <= awId_d;
            awAddr_q  <= awAddr_d;
            awLen_q   <= awLen_d;
            awBurst_q <= awBurst_d;
            wBeat_q   <= wBeat_d;
            wErr_q    <= wErr_d;
            awReady_q <= (wState_d == W_Idle);
            wReady_q  <= (wState_d == W_Data);
            bValid_q  <= (wState_d == W_Resp);
        end
    end

    // RAM byte writes. Contents are not cleared by reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (memWe && !S_AXI_ARESET) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[addrIndex(awAddr_q)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    assign S_AXI_AWREADY = awReady_q;
    assign S_AXI_WREADY  = wReady_q;
    assign S_AXI_BVALID  = bValid_q;
    assign S_AXI_BID     = awId_q;
    assign S_AXI_BRESP   = wErr_q ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read channel ----------------
    rState_t             rState_q, rState_d;
    logic [WIDTH_ID-1:0] arId_q, arId_d;
    logic [WIDTH_AD-1:0] arAddr_q, arAddr_d;
    logic [3:0]          arLen_q, arLen_d;
    logic [1:0]          arBurst_q, arBurst_d;
    logic [3:0]          rBeat_q, rBeat_d;
    logic                rLast_q, rLast_d;
    logic [1:0]          rResp_q, rResp_d;
    logic                arReady_q, rValid_q;
    logic [WIDTH_DA-1:0] rData_q;
    logic                rLoad;
    logic [WIDTH_AD-1:0] rLoadAddr;

    // Read FSM next state. The data register is loaded one beat ahead, so the
    // data for a beat is already on RDATA when that beat is presented. The load
    // happens on the address handshake and again on each accepted beat that is not the last.
    always_comb begin
        rState_d  = rState_q;
        arId_d    = arId_q;
        arAddr_d  = arAddr_q;
        arLen_d   = arLen_q;
        arBurst_d = arBurst_q;
        rBeat_d   = rBeat_q;
        rLast_d   = rLast_q;
        rResp_d   = rResp_q;
        rLoad     = 1'b0;
        rLoadAddr = arAddr_q;
        case (rState_q)
            R_Idle: begin
                if (S_AXI_ARVALID && arReady_q) begin
                    arId_d    = S_AXI_ARID;
                    arAddr_d  = S_AXI_ARADDR;
                    arLen_d   = S_AXI_ARLEN;
                    arBurst_d = S_AXI_ARBURST;
                    rBeat_d   = 4'd0;
                    rLoad     = 1'b1;
                    rLoadAddr = S_AXI_ARADDR;
                    rLast_d   = (S_AXI_ARLEN == 4'd0);
                    rResp_d   = (!addrInRange(S_AXI_ARADDR) || S_AXI_ARBURST[1])
                              ? RESP_SLVERR : RESP_OKAY;
                    rState_d  = R_Data;
                end
            end
            R_Data: begin
                if (S_AXI_RREADY && rValid_q) begin
                    if (rBeat_q == arLen_q) begin
                        rLast_d  = 1'b0;
                        rState_d = R_Idle;
                    end else begin
                        rLoadAddr = nextBeatAddr(arAddr_q, arBurst_q);
                        arAddr_d  = rLoadAddr;
                        rLoad     = 1'b1;
                        rBeat_d   = rBeat_q + 4'd1;
                        rLast_d   = ((rBeat_q + 4'd1) == arLen_q);
                        rResp_d   = (!addrInRange(rLoadAddr) || arBurst_q[1])
                                  ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            default: rState_d = R_Idle;
        endcase
    end

    // Read state and data registers. The RAM is read with the old value of mem,
    // so a read and a write to the same word in the same cycle return the old contents.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rState_q  <= R_Idle;
            arId_q    <= '0;
            arAddr_q  <= '0;
            arLen_q   <= '0;
            arBurst_q <= '0;
            rBeat_q   <= '0;
            rLast_q   <= 1'b0;
            rResp_q   <= RESP_OKAY;
            rData_q   <= '0;
            arReady_q <= 1'b0;
            rValid_q  <= 1'b0;
        end else begin
            rState_q  <= rState_d;
            arId_q    <= arId_d;
            arAddr_q  <= arAddr_d;
            arLen_q   <= arLen_d;
            arBurst_q <= arBurst_d;
            rBeat_q   <= rBeat_d;
            rLast_q   <= rLast_d;
            rResp_q   <= rResp_d;
            arReady_q <= (rState_d == R_Idle);
            rValid_q  <= (rState_d == R_Data);
            if (rLoad) begin
                rData_q <= addrInRange(rLoadAddr) ? mem[addrIndex(rLoadAddr)] : '0;
            end
        end
    end

    assign S_AXI_ARREADY = arReady_q;
    assign S_AXI_RVALID  = rValid_q;
    assign S_AXI_RID     = arId_q;
    assign S_AXI_RDATA   = rData_q;
    assign S_AXI_RRESP   = rResp_q;
    assign S_AXI_RLAST   = rLast_q;

endmodule

// File: tb/tb_axi_s_mem.sv
// tb_axi_s_mem
// Directed bench for axi_s_mem. A compact AXI master drives bursts with
// hand-computed expected data and responses. It also checks handshake
// timing, stall stability, behaviour at the end of the RAM, and reset in the middle of a burst.
module tb_axi_s_mem;

    localparam int WIDTH_ID = 1;
    localparam int WIDTH_AD = 32;
    localparam int WIDTH_DA = 32;
    localparam int TIMEOUT  = 50;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;

    logic clock = 1'b0;
    logic reset;

    logic [WIDTH_ID-1:0] awId;
    logic [WIDTH_AD-1:0] awAddr;
    logic [3:0]          awLen;
    logic [2:0]          awSize;
    logic [1:0]          awBurst;
    logic                awValid, awReady;
    logic [WIDTH_DA-1:0] wDataIn;
    logic [3:0]          wStrbIn;
    logic                wLast, wValid, wReady;
    logic [WIDTH_ID-1:0] bId;
    logic [1:0]          bResp;
    logic                bValid, bReady;
    logic [WIDTH_ID-1:0] arId;
    logic [WIDTH_AD-1:0] arAddr;
    logic [3:0]          arLen;
    logic [2:0]          arSize;
    logic [1:0]          arBurst;
    logic                arValid, arReady;
    logic [WIDTH_ID-1:0] rId;
    logic [WIDTH_DA-1:0] rData;
    logic [1:0]          rResp;
    logic                rLast, rValid, rReady;

    logic [31:0] wData   [16];
    logic [3:0]  wStrb   [16];
    logic [31:0] expData [16];
    logic [1:0]  expResp [16];

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clock = ~clock;

    axi_s_mem #(
        .SLV_ADDR_BASE (32'h0000_0000),
        .DEPTH_WORDS   (1024),
        .WIDTH_ID      (WIDTH_ID),
        .WIDTH_AD      (WIDTH_AD),
        .WIDTH_DA      (WIDTH_DA)
    ) dut (
        .S_AXI_ACLK    (clock),
        .S_AXI_ARESET  (reset),
        .S_AXI_AWID    (awId),
        .S_AXI_AWADDR  (awAddr),
        .S_AXI_AWLEN   (awLen),
        .S_AXI_AWSIZE  (awSize),
        .S_AXI_AWBURST (awBurst),
        .S_AXI_AWVALID (awValid),
        .S_AXI_AWREADY (awReady),
        .S_AXI_WDATA   (wDataIn),
        .S_AXI_WSTRB   (wStrbIn),
        .S_AXI_WLAST   (wLast),
        .S_AXI_WVALID  (wValid),
        .S_AXI_WREADY  (wReady),
        .S_AXI_BID     (bId),
        .S_AXI_BRESP   (bResp),
        .S_AXI_BVALID  (bValid),
        .S_AXI_BREADY  (bReady),
        .S_AXI_ARID    (arId),
        .S_AXI_ARADDR  (arAddr),
        .S_AXI_ARLEN   (arLen),
        .S_AXI_ARSIZE  (arSize),
        .S_AXI_ARBURST (arBurst),
        .S_AXI_ARVALID (arValid),
        .S_AXI_ARREADY (arReady),
        .S_AXI_RID     (rId),
        .S_AXI_RDATA   (rData),
        .S_AXI_RRESP   (rResp),
        .S_AXI_RLAST   (rLast),
        .S_AXI_RVALID  (rValid),
        .S_AXI_RREADY  (rReady)
    );

    // Every comparison goes through here and is counted.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Step to just after the next rising edge. Both driving and sampling happen here.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Drives one write burst from wData and wStrb. earlyLast >= 0 puts WLAST on
    // that beat instead of the last one. bDelay holds BREADY low for that many cycles.
    task automatic writeBurst(input logic [WIDTH_ID-1:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [1:0] burst,
                              input int earlyLast, input int bDelay, input logic [1:0] expB);
        int n;
        awId = id; awAddr = addr; awLen = len; awSize = 3'b010; awBurst = burst;
        awValid = 1'b1;
        n = 0;
        while (!awReady && n < TIMEOUT) begin tick; n++; end
        if (n >= TIMEOUT) checkOutput("awready_timeout", 32'd0, 32'd1);
        tick;
        awValid = 1'b0;
        checkOutput("awready_drop", awReady, 32'd0);
        checkOutput("wready_rise", wReady, 32'd1);
        for (int b = 0; b <= int'(len); b++) begin
            wDataIn = wData[b];
            wStrbIn = wStrb[b];
            wLast   = (earlyLast >= 0) ? (b == earlyLast) : (b == int'(len));
            wValid  = 1'b1;
            n = 0;
            while (!wReady && n < TIMEOUT) begin tick; n++; end
            if (n >= TIMEOUT) checkOutput($sformatf("wready_timeout[%0d]", b), 32'd0, 32'd1);
            tick;
        end
        wValid = 1'b0;
        wLast  = 1'b0;
        checkOutput("bvalid_rise", bValid, 32'd1);
        checkOutput("wready_drop", wReady, 32'd0);
        for (int s = 0; s < bDelay; s++) begin
            tick;
            checkOutput($sformatf("bvalid_hold[%0d]", s), bValid, 32'd1);
            checkOutput($sformatf("awready_stall[%0d]", s), awReady, 32'd0);
        end
        checkOutput("bresp", bResp, expB);
        checkOutput("bid", bId, id);
        bReady = 1'b1;
        tick;
        bReady = 1'b0;
        checkOutput("awready_back", awReady, 32'd1);
        checkOutput("bvalid_drop", bValid, 32'd0);
    endtask

    // Drives one read burst and compares each beat against expData and expResp.
    // With stall set, RREADY follows the pattern 1,0,0,1,0,0,... and the outputs must hold while stalled.
    task automatic readBurst(input logic [WIDTH_ID-1:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [1:0] burst, input bit stall);
        int n;
        arId = id; arAddr = addr; arLen = len; arSize = 3'b010; arBurst = burst;
        arValid = 1'b1;
        n = 0;
        while (!arReady && n < TIMEOUT) begin tick; n++; end
        if (n >= TIMEOUT) checkOutput("arready_timeout", 32'd0, 32'd1);
        tick;
        arValid = 1'b0;
        checkOutput("arready_drop", arReady, 32'd0);
        for (int b = 0; b <= int'(len); b++) begin
            checkOutput($sformatf("rvalid[%0d]", b), rValid, 32'd1);
            checkOutput($sformatf("rdata[%0d]", b), rData, expData[b]);
            checkOutput($sformatf("rresp[%0d]", b), rResp, expResp[b]);
            checkOutput($sformatf("rlast[%0d]", b), rLast, (b == int'(len)));
            checkOutput($sformatf("rid[%0d]", b), rId, id);
            if (stall && b > 0) begin
                rReady = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    tick;
                    checkOutput($sformatf("rdata_hold[%0d]", b), rData, expData[b]);
                    checkOutput($sformatf("rlast_hold[%0d]", b), rLast, (b == int'(len)));
                    checkOutput($sformatf("rresp_hold[%0d]", b), rResp, expResp[b]);
                end
            end
            rReady = 1'b1;
            tick;
        end
        rReady = 1'b0;
        checkOutput("arready_back", arReady, 32'd1);
        checkOutput("rvalid_drop", rValid, 32'd0);
    endtask

    // The whole directed sequence.
    task automatic applyStimulus;
        int n;
        // Reset values, then the ready flags rise one edge after release.
        reset = 1'b1;
        repeat (3) tick;
        checkOutput("rst_awready", awReady, 32'd0);
        checkOutput("rst_arready", arReady, 32'd0);
        checkOutput("rst_wready", wReady, 32'd0);
        checkOutput("rst_bvalid", bValid, 32'd0);
        checkOutput("rst_rvalid", rValid, 32'd0);
        checkOutput("rst_rlast", rLast, 32'd0);
        checkOutput("rst_rdata", rData, 32'd0);
        checkOutput("rst_bresp", bResp, 32'd0);
        checkOutput("rst_rresp", rResp, 32'd0);
        checkOutput("rst_bid", bId, 32'd0);
        checkOutput("rst_rid", rId, 32'd0);
        reset = 1'b0;
        tick;
        checkOutput("post_rst_awready", awReady, 32'd1);
        checkOutput("post_rst_arready", arReady, 32'd1);

        // A WVALID presented before the address is not accepted.
        wValid = 1'b1; wDataIn = 32'hBAD0BAD0; wStrbIn = 4'hF;
        tick;
        checkOutput("wready_idle0", wReady, 32'd0);
        tick;
        checkOutput("wready_idle1", wReady, 32'd0);
        wValid = 1'b0;

        // Four-beat INCR write and read-back.
        for (int i = 0; i < 4; i++) begin
            wData[i]   = 32'h11111111 * (i + 1);
            wStrb[i]   = 4'hF;
            expData[i] = 32'h11111111 * (i + 1);
            expResp[i] = OKAY;
        end
        writeBurst(1'b1, 32'h10, 4'd3, INCR, -1, 0, OKAY);
        readBurst(1'b1, 32'h10, 4'd3, INCR, 1'b0);

        // Byte strobes merge into the existing word.
        wData[0] = 32'h12345678; wStrb[0] = 4'hF;
        writeBurst(1'b0, 32'h100, 4'd0, INCR, -1, 0, OKAY);
        wData[0] = 32'hAABBCCDD; wStrb[0] = 4'b0101;
        writeBurst(1'b0, 32'h100, 4'd0, INCR, -1, 0, OKAY);
        expData[0] = 32'h12BB56DD; expResp[0] = OKAY;
        readBurst(1'b0, 32'h100, 4'd0, INCR, 1'b0);

        // In a FIXED burst every beat hits the same word, so the last beat wins.
        wData[0] = 32'hA0A0A0A0; wData[1] = 32'hB0B0B0B0; wData[2] = 32'hC0C0C0C0;
        for (int i = 0; i < 3; i++) begin
            wStrb[i] = 4'hF; expData[i] = 32'hC0C0C0C0; expResp[i] = OKAY;
        end
        writeBurst(1'b1, 32'h200, 4'd2, FIXED, -1, 0, OKAY);
        readBurst(1'b1, 32'h200, 4'd2, FIXED, 1'b0);

        // Burst that runs off the last word of the RAM.
        wData[0] = 32'hCAFEF00D; wData[1] = 32'hDEADBEEF;
        wStrb[0] = 4'hF; wStrb[1] = 4'hF;
        writeBurst(1'b0, 32'hFFC, 4'd1, INCR, -1, 0, SLVERR);
        expData[0] = 32'hCAFEF00D; expResp[0] = OKAY;
        expData[1] = 32'h0;        expResp[1] = SLVERR;
        readBurst(1'b0, 32'hFFC, 4'd1, INCR, 1'b0);

        // Reserved burst types run as INCR and report SLVERR.
        wData[0] = 32'h01020304; wData[1] = 32'h05060708;
        writeBurst(1'b1, 32'h600, 4'd1, 2'b10, -1, 0, SLVERR);
        expData[0] = 32'h01020304; expData[1] = 32'h05060708;
        expResp[0] = SLVERR;       expResp[1] = SLVERR;
        readBurst(1'b1, 32'h600, 4'd1, 2'b11, 1'b0);

        // Read stalls on RREADY, then a write held for five cycles on BREADY.
        for (int i = 0; i < 4; i++) begin
            expData[i] = 32'h11111111 * (i + 1);
            expResp[i] = OKAY;
        end
        readBurst(1'b0, 32'h10, 4'd3, INCR, 1'b1);
        wData[0] = 32'h5A5A5A5A; wStrb[0] = 4'hF;
        writeBurst(1'b0, 32'h300, 4'd0, INCR, -1, 5, OKAY);

        // WLAST arriving early on beat 1 of a four-beat write.
        for (int i = 0; i < 4; i++) begin
            wData[i] = 32'h70000000 + i; wStrb[i] = 4'hF;
        end
        writeBurst(1'b1, 32'h700, 4'd3, INCR, 1, 0, SLVERR);

        // Reset while beat 2 of a read is being presented.
        arId = 1'b0; arAddr = 32'h10; arLen = 4'd3; arBurst = INCR; arValid = 1'b1;
        n = 0;
        while (!arReady && n < TIMEOUT) begin tick; n++; end
        if (n >= TIMEOUT) checkOutput("mid_arready_timeout", 32'd0, 32'd1);
        tick;
        arValid = 1'b0;
        rReady  = 1'b1;
        tick;
        tick;
        checkOutput("mid_rdata_b2", rData, 32'h33333333);
        reset = 1'b1;
        tick;
        rReady = 1'b0;
        checkOutput("mid_rvalid_reset", rValid, 32'd0);
        checkOutput("mid_arready_reset", arReady, 32'd0);
        reset = 1'b0;
        tick;
        checkOutput("mid_arready_release", arReady, 32'd1);
        expData[0] = 32'h11111111; expResp[0] = OKAY;
        readBurst(1'b0, 32'h10, 4'd0, INCR, 1'b0);
        expData[0] = 32'h12BB56DD;
        readBurst(1'b0, 32'h100, 4'd0, INCR, 1'b0);
    endtask

    // Main sequence: drive idle defaults, run the stimulus, print the summary.
    initial begin
        reset = 1'b1;
        awId = '0; awAddr = '0; awLen = '0; awSize = '0; awBurst = '0; awValid = 1'b0;
        wDataIn = '0; wStrbIn = '0; wLast = 1'b0; wValid = 1'b0; bReady = 1'b0;
        arId = '0; arAddr = '0; arLen = '0; arSize = '0; arBurst = '0; arValid = 1'b0;
        rReady = 1'b0;
        applyStimulus;
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

    // Guard against a hung handshake the bounded waits did not catch.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
